// File: rtl/vram_dump.sv
// vram_dump: SPI responder (mode 0) streaming Specialist VRAM bitmap/colour bytes to the ARM.
// Defining VRAM_DUMP_CRC_EN adds a CRC-8 over dumped bytes, read back with CMD_CRC.
`timescale 1ns/1ps
module vram_dump #(
  parameter logic [7:0] CMD_BMP = 8'h5A,
  parameter logic [7:0] CMD_CLR = 8'h5B,
  parameter logic [7:0] CMD_CRC = 8'h5F
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        SPI_SCK,
  input  logic        SPI_SS4,
  input  logic        SPI_DI,
  output logic        SPI_DO,
  output logic        SPI_DO_OE,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [10:0] vram_q,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_FETCH, S_SEND, S_IGNORE
  } state_t;
  typedef enum logic [1:0] {MODE_BMP, MODE_CLR, MODE_CRC} mode_t;

  localparam logic [13:0] ADDR_LAST = 14'h2FFF;
  localparam logic [13:0] ADDR_END  = 14'h3000;

  state_t      state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [2:0]  sck_pipe_q, sck_pipe_d;
  logic [2:0]  ss_pipe_q, ss_pipe_d;
  logic [1:0]  di_pipe_q, di_pipe_d;
  logic [6:0]  rx_q, rx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  addr_hi_q, addr_hi_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  pre_q, pre_d;
  logic        rd_q, rd_d;
  logic [1:0]  rd_pipe_q, rd_pipe_d;
  logic        rise_seen_q, rise_seen_d;

  logic        sck_rise, sck_fall, ss_rise, ss_fall, di_s, byte_done;
  logic [7:0]  rx_byte, rd_data, reload_byte;
  logic [13:0] start_addr, addr_inc;

`ifdef VRAM_DUMP_CRC_EN
  logic [7:0]  crc_q, crc_d, crc_run_q, crc_run_d, crc_step;
`endif

  assign sck_rise   = sck_pipe_q[1] & ~sck_pipe_q[2];
  assign sck_fall   = ~sck_pipe_q[1] & sck_pipe_q[2];
  assign ss_rise    = ss_pipe_q[1] & ~ss_pipe_q[2];
  assign ss_fall    = ~ss_pipe_q[1] & ss_pipe_q[2];
  assign di_s       = di_pipe_q[1];
  assign rx_byte    = {rx_q, di_s};
  assign byte_done  = sck_rise && (cnt_q == 3'd7);
  assign start_addr = {addr_hi_q, rx_byte};
  assign addr_inc   = (addr_q == ADDR_LAST) ? '0 : addr_q + 14'd1;
  assign rd_data    = (mode_q == MODE_CLR) ? {5'b0, vram_q[10:8]} : vram_q[7:0];

`ifdef VRAM_DUMP_CRC_EN
  // Bitwise MSB-first CRC-8 (poly 0x07) fed with the bit the initiator samples.
  assign crc_step    = {crc_run_q[6:0], 1'b0} ^ ((crc_run_q[7] ^ tx_q[7]) ? 8'h07 : 8'h00);
  assign reload_byte = (mode_q == MODE_CRC) ? crc_q : pre_q;
`else
  assign reload_byte = pre_q;
`endif

  // Synchroniser chains reset to "SS low", so a low SS at reset release yields no
  // fall edge and the block waits for SS to go high first.
  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_BMP;
      sck_pipe_q  <= '0;
      ss_pipe_q   <= '0;
      di_pipe_q   <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      pre_q       <= '0;
      rd_q        <= 1'b0;
      rd_pipe_q   <= '0;
      rise_seen_q <= 1'b0;
`ifdef VRAM_DUMP_CRC_EN
      crc_q       <= '0;
      crc_run_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sck_pipe_q  <= sck_pipe_d;
      ss_pipe_q   <= ss_pipe_d;
      di_pipe_q   <= di_pipe_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      pre_q       <= pre_d;
      rd_q        <= rd_d;
      rd_pipe_q   <= rd_pipe_d;
      rise_seen_q <= rise_seen_d;
`ifdef VRAM_DUMP_CRC_EN
      crc_q       <= crc_d;
      crc_run_q   <= crc_run_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ss_fall) state_d = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          if (rx_byte == CMD_BMP || rx_byte == CMD_CLR) state_d = S_ADDR_H;
`ifdef VRAM_DUMP_CRC_EN
          else if (rx_byte == CMD_CRC)                  state_d = S_FETCH;
`else
          else if (rx_byte == CMD_CRC)                  state_d = S_IGNORE;
`endif
          else                                          state_d = S_IGNORE;
        end
      end
      S_ADDR_H: if (byte_done) state_d = S_ADDR_L;
      S_ADDR_L: if (byte_done) state_d = S_FETCH;
      S_FETCH:  if (mode_q == MODE_CRC || rd_pipe_q[1]) state_d = S_SEND;
      S_SEND:   state_d = S_SEND;
      S_IGNORE: state_d = S_IGNORE;
      default:  state_d = S_IDLE;
    endcase
    if (ss_rise) state_d = S_IDLE;
  end

  always_comb begin
    sck_pipe_d  = {sck_pipe_q[1:0], SPI_SCK};
    ss_pipe_d   = {ss_pipe_q[1:0], SPI_SS4};
    di_pipe_d   = {di_pipe_q[0], SPI_DI};
    mode_d      = mode_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    pre_d       = pre_q;
    rd_d        = 1'b0;
    rd_pipe_d   = {rd_pipe_q[0], rd_q};
    rise_seen_d = rise_seen_q;
`ifdef VRAM_DUMP_CRC_EN
    crc_d       = crc_q;
    crc_run_d   = crc_run_q;
`endif

    if (sck_rise) begin
      rx_d  = rx_byte[6:0];
      cnt_d = cnt_q + 3'd1;
    end
    if (ss_fall) cnt_d = '0;

    case (state_q)
      S_CMD: begin
        if (byte_done) begin
          rise_seen_d = 1'b0;
          if (rx_byte == CMD_CLR)      mode_d = MODE_CLR;
          else if (rx_byte == CMD_BMP) mode_d = MODE_BMP;
          else                         mode_d = MODE_CRC;
`ifdef VRAM_DUMP_CRC_EN
          if (rx_byte == CMD_BMP || rx_byte == CMD_CLR) begin
            crc_d     = '0;
            crc_run_d = '0;
          end
`endif
        end
      end
      S_ADDR_H: if (byte_done) addr_hi_d = rx_byte[5:0];
      S_ADDR_L: begin
        if (byte_done) begin
          addr_d      = (start_addr < ADDR_END) ? start_addr : '0;
          rd_d        = 1'b1;
          rise_seen_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (mode_q == MODE_CRC) tx_d = reload_byte;
        else if (rd_pipe_q[1])  tx_d = rd_data;
      end
      S_SEND: begin
        if (rd_pipe_q[1]) pre_d = rd_data;
        if (sck_rise) begin
          rise_seen_d = 1'b1;
`ifdef VRAM_DUMP_CRC_EN
          if (mode_q != MODE_CRC) begin
            crc_run_d = crc_step;
            if (cnt_q == 3'd7) crc_d = crc_step;
          end
`endif
        end
        // The fall trailing the last command/address bit has no preceding data
        // rise, so it is skipped; the 8th fall of each byte loads the prefetch.
        if (sck_fall && rise_seen_q) begin
          rise_seen_d = 1'b0;
          if (cnt_q == 3'd0) begin
            tx_d = reload_byte;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
            if (cnt_q == 3'd7 && mode_q != MODE_CRC) begin
              addr_d = addr_inc;
              rd_d   = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    if (ss_rise) rd_d = 1'b0;
  end

  always_comb begin
    SPI_DO    = 1'b0;
    SPI_DO_OE = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_ADDR_H, S_ADDR_L: busy = 1'b1;
      S_FETCH: begin
        SPI_DO_OE = 1'b1;
        busy      = 1'b1;
      end
      S_SEND: begin
        SPI_DO    = tx_q[7];
        SPI_DO_OE = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign vram_rd   = rd_q;
  assign vram_addr = addr_q;

endmodule

// File: tb/tb_vram_dump.sv
// Directed bench for vram_dump: SPI mode-0 initiator plus a 2-cycle-latency VRAM model.
`timescale 1ns/1ps
module tb_vram_dump;

  localparam int HALF = 100;

  logic        clk_ram = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        di = 1'b0;
  logic        do_o, oe, rd, busy;
  logic [13:0] addr;
  logic [10:0] q, p1;
  logic [10:0] mem [0:16383];

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, oe_cnt = 0, busy_cnt = 0;

  always #5 clk_ram = ~clk_ram;

  vram_dump dut (
    .clk_ram   (clk_ram),
    .reset     (reset),
    .SPI_SCK   (sck),
    .SPI_SS4   (ss),
    .SPI_DI    (di),
    .SPI_DO    (do_o),
    .SPI_DO_OE (oe),
    .vram_addr (addr),
    .vram_rd   (rd),
    .vram_q    (q),
    .busy      (busy)
  );

  always @(posedge clk_ram) begin
    p1 <= mem[addr];
    q  <= p1;
    if (rd)   rd_cnt   <= rd_cnt + 1;
    if (oe)   oe_cnt   <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      di = b[i];
      #HALF;
      r[i] = do_o;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      di = 1'b0;
      #HALF;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic spi_cmd3(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    logic [7:0] r;
    ss = 1'b0;
    #HALF;
    spi_byte(c, r);
    spi_byte(h, r);
    spi_byte(l, r);
  endtask

  task automatic spi_close();
    #(2*HALF);
    ss = 1'b1;
    #(3*HALF);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk_ram);
    @(negedge clk_ram);
    checks++; if (do_o !== 1'b0)   begin failures++; $display("FAIL reset_do got=%b exp=0", do_o); end
    checks++; if (oe !== 1'b0)     begin failures++; $display("FAIL reset_oe got=%b exp=0", oe); end
    checks++; if (rd !== 1'b0)     begin failures++; $display("FAIL reset_rd got=%b exp=0", rd); end
    checks++; if (addr !== 14'h0)  begin failures++; $display("FAIL reset_addr got=%h exp=0000", addr); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (10) @(posedge clk_ram);
  endtask

  task automatic test_bitmap();
    logic [7:0] r;
    logic [7:0] exp [3];
    int base;
    exp = '{8'hA5, 8'h3C, 8'hFF};
    mem[0] = {3'd5, 8'hA5};
    mem[1] = {3'd3, 8'h3C};
    mem[2] = {3'd7, 8'hFF};
    mem[3] = {3'd1, 8'h11};
    base = rd_cnt;
    ss = 1'b0;
    #HALF;
    spi_byte(8'h5A, r);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bmp_busy_after_cmd got=%b exp=1", busy); end
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL bmp_oe_after_addr got=%b exp=1", oe); end
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'h00, r);
      checks++; if (r !== exp[i]) begin failures++; $display("FAIL bmp_byte%0d got=%h exp=%h", i, r, exp[i]); end
    end
    spi_close();
    checks++; if (rd_cnt - base !== 4) begin failures++; $display("FAIL bmp_rd_count got=%0d exp=4", rd_cnt - base); end
    checks++; if (addr !== 14'h0003) begin failures++; $display("FAIL bmp_end_addr got=%h exp=0003", addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bmp_busy_end got=%b exp=0", busy); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL bmp_oe_end got=%b exp=0", oe); end
  endtask

  task automatic test_colour_wrap();
    logic [7:0] r;
    mem[14'h2FFF] = {3'd5, 8'h77};
    mem[0]        = {3'd2, 8'hA5};
    spi_cmd3(8'h5B, 8'h2F, 8'hFF);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h05) begin failures++; $display("FAIL clr_last got=%h exp=05", r); end
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h02) begin failures++; $display("FAIL clr_wrap got=%h exp=02", r); end
    spi_close();
    spi_cmd3(8'h5A, 8'h30, 8'h00);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'hA5) begin failures++; $display("FAIL start_clamp got=%h exp=a5", r); end
    spi_close();
    spi_cmd3(8'h5A, 8'hC0, 8'h01);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h3C) begin failures++; $display("FAIL addr_hi_mask got=%h exp=3c", r); end
    spi_close();
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] r;
    logic [7:0] acc;
    int rd0, oe0, busy0;
    rd0 = rd_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    acc = '0;
    spi_cmd3(8'h11, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, r);
      acc = acc | r;
    end
    spi_close();
    checks++; if (acc !== 8'h00) begin failures++; $display("FAIL unk_do got=%h exp=00", acc); end
    checks++; if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL unk_oe_cycles got=%0d exp=0", oe_cnt - oe0); end
    checks++; if (busy_cnt - busy0 !== 0) begin failures++; $display("FAIL unk_busy_cycles got=%0d exp=0", busy_cnt - busy0); end
    checks++; if (rd_cnt - rd0 !== 0) begin failures++; $display("FAIL unk_rd got=%0d exp=0", rd_cnt - rd0); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    mem[14'h10] = {3'd0, 8'h96};
    mem[14'h11] = {3'd0, 8'h4B};
    spi_cmd3(8'h5A, 8'h00, 8'h00);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'hA5) begin failures++; $display("FAIL abort_first got=%h exp=a5", r); end
    spi_bits(4);
    spi_close();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    spi_cmd3(8'h5A, 8'h00, 8'h10);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h96) begin failures++; $display("FAIL abort_new0 got=%h exp=96", r); end
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h4B) begin failures++; $display("FAIL abort_new1 got=%h exp=4b", r); end
    spi_close();
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int rd0, oe0, busy0;
    spi_cmd3(8'h5A, 8'h00, 8'h01);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h3C) begin failures++; $display("FAIL rmid_first got=%h exp=3c", r); end
    spi_bits(3);
    @(posedge clk_ram);
    reset = 1'b1;
    repeat (3) @(posedge clk_ram);
    @(negedge clk_ram);
    checks++; if (do_o !== 1'b0)  begin failures++; $display("FAIL rmid_do got=%b exp=0", do_o); end
    checks++; if (oe !== 1'b0)    begin failures++; $display("FAIL rmid_oe got=%b exp=0", oe); end
    checks++; if (rd !== 1'b0)    begin failures++; $display("FAIL rmid_rd got=%b exp=0", rd); end
    checks++; if (addr !== 14'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0000", addr); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (5) @(posedge clk_ram);
    rd0 = rd_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
    spi_byte(8'h5A, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    spi_byte(8'h00, r);
    checks++; if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL rmid_ignore_oe got=%0d exp=0", oe_cnt - oe0); end
    checks++; if (busy_cnt - busy0 !== 0) begin failures++; $display("FAIL rmid_ignore_busy got=%0d exp=0", busy_cnt - busy0); end
    checks++; if (rd_cnt - rd0 !== 0) begin failures++; $display("FAIL rmid_ignore_rd got=%0d exp=0", rd_cnt - rd0); end
    ss = 1'b1;
    #(3*HALF);
    spi_cmd3(8'h5A, 8'h00, 8'h02);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'hFF) begin failures++; $display("FAIL rmid_next got=%h exp=ff", r); end
    spi_close();
  endtask

  task automatic test_crc();
    logic [7:0] r;
    int oe0;
    mem[14'h20] = {3'd0, 8'h01};
    mem[14'h21] = {3'd0, 8'h02};
    spi_cmd3(8'h5A, 8'h00, 8'h20);
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h01) begin failures++; $display("FAIL crc_src0 got=%h exp=01", r); end
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h02) begin failures++; $display("FAIL crc_src1 got=%h exp=02", r); end
    spi_close();
    oe0 = oe_cnt;
    ss = 1'b0;
    #HALF;
    spi_byte(8'h5F, r);
`ifdef VRAM_DUMP_CRC_EN
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL crc_oe got=%b exp=1", oe); end
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, r);
      checks++; if (r !== 8'h1B) begin failures++; $display("FAIL crc_byte%0d got=%h exp=1b", i, r); end
    end
    spi_close();
`else
    spi_byte(8'h00, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL nocrc_do got=%h exp=00", r); end
    spi_close();
    checks++; if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL nocrc_oe got=%0d exp=0", oe_cnt - oe0); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    test_reset();
    test_bitmap();
    test_colour_wrap();
    test_unknown_cmd();
    test_abort();
    test_reset_mid();
    test_crc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
